// File: rtl/swap_arb_pkg.sv
// Shared types and constants for the two-port byte-swapping stream arbiter.
package swap_arb_pkg;

    // Arbiter FSM: waiting for a packet start, or streaming the granted packet.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Number of entries held by the output skid buffer.
    localparam int SKID_DEPTH = 2;

    // Index of an input port (two ports).
    typedef logic [0:0] port_idx_t;

    // Round-robin pick: with both ports requesting, the one that did not win last time
    // gets the grant; otherwise the single requester wins.
    function automatic port_idx_t pick_port(input port_idx_t last_grant,
                                            input logic      req0,
                                            input logic      req1);
        port_idx_t winner;
        if (req0 && req1) begin
            winner = ~last_grant;
        end else if (req0) begin
            winner = 1'b0;
        end else begin
            winner = 1'b1;
        end
        return winner;
    endfunction

endpackage

// File: rtl/axis_skid2.sv
// Two-entry FIFO-ordered skid buffer. The head entry is a register that drives the
// output directly, so the output payload is stable while stalled.
module axis_skid2
    import swap_arb_pkg::*;
#(
    parameter int W = 289
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [1:0]   count_r;
    logic [W-1:0] head_r;
    logic [W-1:0] tail_r;
    logic         push_s;
    logic         pop_s;

    // Ready only while there is space, so a full buffer stalls the source in the same cycle.
    assign in_ready  = (count_r < 2'(SKID_DEPTH));
    assign out_valid = (count_r != 2'd0);
    assign out_data  = head_r;
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // Occupancy and entry storage; push+pop at occupancy 1 replaces the head in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 2'd0;
            head_r  <= {W{1'b0}};
            tail_r  <= {W{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_r <= in_data;
                    end else begin
                        tail_r <= in_data;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    head_r  <= tail_r;
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        head_r <= in_data;
                    end else begin
                        head_r <= tail_r;
                        tail_r <= in_data;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/byte_swap.sv
// Combinational byte reversal: output byte i takes input byte N-1-i.
module byte_swap #(
    parameter int N = 32
) (
    input  logic [8*N-1:0] data,
    output logic [8*N-1:0] swapped
);

    for (genvar i = 0; i < N; i++) begin : g_byte
        assign swapped[8*i +: 8] = data[8*(N-1-i) +: 8];
    end

endmodule

// File: rtl/swap_stream_arbiter.sv
// Two AXI-Stream requesters share one byte-reversal path. Packets are arbitrated
// round-robin; each grant latches that port's swap enable for the whole packet.
// Optional build macro SWAP_ARB_STATS_EN adds packet and swap counters.
module swap_stream_arbiter
    import swap_arb_pkg::*;
#(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [8*N-1:0] s0_tdata,
    input  logic [N-1:0]   s0_tkeep,
    input  logic           s0_tlast,
    input  logic           s0_tvalid,
    output logic           s0_tready,
    input  logic           s0_swap_en,
    input  logic [8*N-1:0] s1_tdata,
    input  logic [N-1:0]   s1_tkeep,
    input  logic           s1_tlast,
    input  logic           s1_tvalid,
    output logic           s1_tready,
    input  logic           s1_swap_en,
    output logic [8*N-1:0] m_tdata,
    output logic [N-1:0]   m_tkeep,
    output logic           m_tlast,
    output logic           m_tvalid,
    input  logic           m_tready,
    output logic           grant_id
`ifdef SWAP_ARB_STATS_EN
    ,
    output logic [31:0]    pkt_cnt0,
    output logic [31:0]    pkt_cnt1,
    output logic [31:0]    swap_cnt
`endif
);

    localparam int DW = 8 * N;
    localparam int PW = 9 * N + 1;

    arb_state_e     state_r, state_s;
    port_idx_t      grant_r, grant_s;
    port_idx_t      last_grant_r, last_grant_s;
    logic           swap_r, swap_s;

    logic [DW-1:0]  sel_data_s;
    logic [N-1:0]   sel_keep_s;
    logic           sel_last_s;
    logic           sel_valid_s;
    logic           sel_ready_s;
    logic           accept_s;
    logic [DW-1:0]  data_rev_s;
    logic [N-1:0]   keep_rev_s;
    logic [DW-1:0]  data_out_s;
    logic [N-1:0]   keep_out_s;
    logic [PW-1:0]  payload_s;
    logic [PW-1:0]  skid_out_s;
    logic           skid_in_ready_s;

    // FSM state, grant and latched swap enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            swap_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
            swap_r       <= swap_s;
        end
    end

    // Next-state: grant in IDLE (no beat accepted there), return to IDLE after the tlast beat.
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        last_grant_s = last_grant_r;
        swap_s       = swap_r;
        case (state_r)
            ST_IDLE: begin
                if (s0_tvalid || s1_tvalid) begin
                    grant_s      = pick_port(last_grant_r, s0_tvalid, s1_tvalid);
                    last_grant_s = grant_s;
                    swap_s       = (grant_s == 1'b1) ? s1_swap_en : s0_swap_en;
                    state_s      = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (accept_s && sel_last_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Route the granted port's beat into the shared datapath.
    always_comb begin
        if (grant_r == 1'b1) begin
            sel_data_s  = s1_tdata;
            sel_keep_s  = s1_tkeep;
            sel_last_s  = s1_tlast;
            sel_valid_s = s1_tvalid;
        end else begin
            sel_data_s  = s0_tdata;
            sel_keep_s  = s0_tkeep;
            sel_last_s  = s0_tlast;
            sel_valid_s = s0_tvalid;
        end
    end

    assign sel_ready_s = (state_r == ST_BUSY) && skid_in_ready_s;
    assign accept_s    = sel_valid_s && sel_ready_s;
    assign s0_tready   = sel_ready_s && (grant_r == 1'b0);
    assign s1_tready   = sel_ready_s && (grant_r == 1'b1);
    assign grant_id    = grant_r;

    byte_swap #(.N(N)) u_data_swap (
        .data    (sel_data_s),
        .swapped (data_rev_s)
    );

    // Keep bits are reversed alongside their bytes.
    always_comb begin
        keep_rev_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            keep_rev_s[i] = sel_keep_s[N-1-i];
        end
    end

    // Apply the per-packet swap decision; tlast always passes through.
    always_comb begin
        if (swap_r) begin
            data_out_s = data_rev_s;
            keep_out_s = keep_rev_s;
        end else begin
            data_out_s = sel_data_s;
            keep_out_s = sel_keep_s;
        end
    end

    assign payload_s = {sel_last_s, keep_out_s, data_out_s};

    axis_skid2 #(.W(PW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (payload_s),
        .in_valid  (sel_valid_s && (state_r == ST_BUSY)),
        .in_ready  (skid_in_ready_s),
        .out_data  (skid_out_s),
        .out_valid (m_tvalid),
        .out_ready (m_tready)
    );

    assign m_tlast = skid_out_s[PW-1];
    assign m_tkeep = skid_out_s[DW +: N];
    assign m_tdata = skid_out_s[DW-1:0];

`ifdef SWAP_ARB_STATS_EN
    logic [31:0] pkt_cnt0_r;
    logic [31:0] pkt_cnt1_r;
    logic [31:0] swap_cnt_r;

    // Count completed packets per port and completed swapped packets; wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt0_r <= 32'd0;
            pkt_cnt1_r <= 32'd0;
            swap_cnt_r <= 32'd0;
        end else if (accept_s && sel_last_s) begin
            if (grant_r == 1'b1) begin
                pkt_cnt1_r <= pkt_cnt1_r + 32'd1;
            end else begin
                pkt_cnt0_r <= pkt_cnt0_r + 32'd1;
            end
            if (swap_r) begin
                swap_cnt_r <= swap_cnt_r + 32'd1;
            end else begin
                swap_cnt_r <= swap_cnt_r;
            end
        end else begin
            pkt_cnt0_r <= pkt_cnt0_r;
        end
    end

    assign pkt_cnt0 = pkt_cnt0_r;
    assign pkt_cnt1 = pkt_cnt1_r;
    assign swap_cnt = swap_cnt_r;
`endif

endmodule

// File: tb/tb_swap_stream_arbiter.sv
// Directed bench for swap_stream_arbiter with N=4.
module tb_swap_stream_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] s0_tdata, s1_tdata;
    logic [3:0]  s0_tkeep, s1_tkeep;
    logic        s0_tlast, s1_tlast, s0_tvalid, s1_tvalid, s0_swap_en, s1_swap_en;
    logic        s0_tready, s1_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast, m_tvalid, m_tready, grant_id;
`ifdef SWAP_ARB_STATS_EN
    logic [31:0] pkt_cnt0, pkt_cnt1, swap_cnt;
`endif

    int errors;
    int checks;
    logic [37:0] out_q[$];
    logic [37:0] exp_q[$];

    swap_stream_arbiter #(.N(4)) dut (
        .clk(clk), .rst(rst),
        .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tlast(s0_tlast),
        .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_swap_en(s0_swap_en),
        .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tlast(s1_tlast),
        .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_swap_en(s1_swap_en),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .grant_id(grant_id)
`ifdef SWAP_ARB_STATS_EN
        , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .swap_cnt(swap_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: records every handshaken beat as {grant, last, keep, data}.
    always @(negedge clk) begin
        if (m_tvalid && m_tready) out_q.push_back({grant_id, m_tlast, m_tkeep, m_tdata});
    end

    function automatic logic [31:0] rev32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic logic [3:0] rev4(input logic [3:0] k);
        return {k[0], k[1], k[2], k[3]};
    endfunction

    // Expected beats of one packet: beat b data = base + b*0x44444444, first keep keep0.
    task automatic add_exp(input int port, input int nbeats, input logic [31:0] base,
                           input logic [3:0] keep0, input logic swap);
        for (int b = 0; b < nbeats; b++) begin
            logic [31:0] d;
            logic [3:0]  k;
            d = base + 32'(b) * 32'h44444444;
            k = (b == 0) ? keep0 : 4'hF;
            if (swap) begin
                d = rev32(d);
                k = rev4(k);
            end
            exp_q.push_back({port[0], (b == nbeats - 1), k, d});
        end
    endtask

    task automatic send_pkt(input int port, input int nbeats, input logic [31:0] base,
                            input logic [3:0] keep0, input logic swap, input logic toggle);
        for (int b = 0; b < nbeats; b++) begin
            logic [31:0] d;
            logic [3:0]  k;
            logic        l, se, rdy;
            int          t;
            d  = base + 32'(b) * 32'h44444444;
            k  = (b == 0) ? keep0 : 4'hF;
            l  = (b == nbeats - 1);
            se = (toggle && b > 0) ? ~swap : swap;
            if (port == 0) begin
                s0_tdata = d; s0_tkeep = k; s0_tlast = l; s0_swap_en = se; s0_tvalid = 1'b1;
            end else begin
                s1_tdata = d; s1_tkeep = k; s1_tlast = l; s1_swap_en = se; s1_tvalid = 1'b1;
            end
            rdy = 1'b0;
            t = 0;
            while (!rdy && t < 200) begin
                @(negedge clk);
                rdy = (port == 0) ? s0_tready : s1_tready;
                t++;
            end
            if (!rdy) begin
                checks++; errors++;
                $display("FAIL send_timeout port=%0d beat=%0d: tready never seen, required 1", port, b);
            end
            @(posedge clk); #1;
        end
        if (port == 0) s0_tvalid = 1'b0; else s1_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s0_tvalid = 1'b0; s1_tvalid = 1'b0; m_tready = 1'b1;
        s0_tdata = 32'h0; s1_tdata = 32'h0; s0_tkeep = 4'h0; s1_tkeep = 4'h0;
        s0_tlast = 1'b0; s1_tlast = 1'b0; s0_swap_en = 1'b0; s1_swap_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 200 && out_q.size() < exp_q.size(); t++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid got=%0b want=0", m_tvalid); end
        checks++; if (s0_tready !== 1'b0) begin errors++; $display("FAIL reset_s0_tready got=%0b want=0", s0_tready); end
        checks++; if (s1_tready !== 1'b0) begin errors++; $display("FAIL reset_s1_tready got=%0b want=0", s1_tready); end
        checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant_id got=%0b want=0", grant_id); end
        @(posedge clk); #1;
    endtask

    task automatic test_swap_port0();
        int c;
        do_reset();
        fork
            send_pkt(0, 3, 32'h11223344, 4'b0111, 1'b1, 1'b0);
            begin
                c = 0;
                @(negedge clk);
                while (!m_tvalid && c < 20) begin c++; @(negedge clk); end
            end
        join
        checks++; if (c !== 2) begin errors++; $display("FAIL swap0_latency got=%0d want=2", c); end
        exp_q.push_back({1'b0, 1'b0, 4'b1110, 32'h44332211});
        exp_q.push_back({1'b0, 1'b0, 4'b1111, 32'h88776655});
        exp_q.push_back({1'b0, 1'b1, 4'b1111, 32'hCCBBAA99});
        wait_drain();
        checks++;
        if (out_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL swap0_count got=%0d want=%0d", out_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL swap0_beat%0d got=%h want=%h", i, out_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_alternate();
        do_reset();
        add_exp(0, 2, 32'h01020304, 4'hF, 1'b1);
        add_exp(1, 2, 32'hA1A2A3A4, 4'hF, 1'b0);
        add_exp(0, 2, 32'h21222324, 4'b0001, 1'b1);
        add_exp(1, 2, 32'hC1C2C3C4, 4'b1100, 1'b0);
        fork
            begin
                send_pkt(0, 2, 32'h01020304, 4'hF, 1'b1, 1'b0);
                send_pkt(0, 2, 32'h21222324, 4'b0001, 1'b1, 1'b0);
            end
            begin
                send_pkt(1, 2, 32'hA1A2A3A4, 4'hF, 1'b0, 1'b0);
                send_pkt(1, 2, 32'hC1C2C3C4, 4'b1100, 1'b0, 1'b0);
            end
        join
        wait_drain();
        checks++;
        if (out_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL alt_count got=%0d want=%0d", out_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL alt_beat%0d got=%h want=%h", i, out_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_swap_toggle();
        do_reset();
        send_pkt(1, 3, 32'hAABBCCDD, 4'b0011, 1'b0, 1'b1);
        send_pkt(1, 2, 32'h10203040, 4'b0111, 1'b1, 1'b1);
        exp_q.push_back({1'b1, 1'b0, 4'b0011, 32'hAABBCCDD});
        exp_q.push_back({1'b1, 1'b0, 4'b1111, 32'hEF001121});
        exp_q.push_back({1'b1, 1'b1, 4'b1111, 32'h33445565});
        add_exp(1, 2, 32'h10203040, 4'b0111, 1'b1);
        wait_drain();
        checks++;
        if (out_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL toggle_count got=%0d want=%0d", out_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL toggle_beat%0d got=%h want=%h", i, out_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [36:0] held;
        logic        low_seen;
        do_reset();
        add_exp(0, 6, 32'h0F1E2D3C, 4'b1010, 1'b0);
        low_seen = 1'b0;
        held = 37'h0;
        fork
            send_pkt(0, 6, 32'h0F1E2D3C, 4'b1010, 1'b0, 1'b0);
            begin
                for (int t = 0; t < 100 && out_q.size() < 2; t++) @(negedge clk);
                @(posedge clk); #1;
                m_tready = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    if (i == 0) held = {m_tlast, m_tkeep, m_tdata};
                    if (!s0_tready) low_seen = 1'b1;
                end
                checks++; if (low_seen !== 1'b1) begin errors++; $display("FAIL bp_tready_low got=%0b want=1", low_seen); end
                checks++; if (s0_tready !== 1'b0) begin errors++; $display("FAIL bp_tready_full got=%0b want=0", s0_tready); end
                checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL bp_m_tvalid got=%0b want=1", m_tvalid); end
                checks++;
                if ({m_tlast, m_tkeep, m_tdata} !== held) begin
                    errors++; $display("FAIL bp_stable got=%h want=%h", {m_tlast, m_tkeep, m_tdata}, held);
                end
                @(posedge clk); #1;
                m_tready = 1'b1;
            end
        join
        wait_drain();
        checks++;
        if (out_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL bp_count got=%0d want=%0d", out_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d got=%h want=%h", i, out_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic rdy;
        do_reset();
        m_tready = 1'b0;
        s0_tdata = 32'h01010101; s0_tkeep = 4'hF; s0_tlast = 1'b0; s0_swap_en = 1'b0; s0_tvalid = 1'b1;
        rdy = 1'b0;
        for (int t = 0; t < 20 && !rdy; t++) begin @(negedge clk); rdy = s0_tready; end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rstmid_beat1_ready got=%0b want=1", rdy); end
        @(posedge clk); #1;
        s0_tdata = 32'h02020202;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; s0_tvalid = 1'b0; m_tready = 1'b1;
        @(negedge clk);
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_m_tvalid got=%0b want=0", m_tvalid); end
        checks++; if (s0_tready !== 1'b0) begin errors++; $display("FAIL rstmid_s0_tready got=%0b want=0", s0_tready); end
        checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL rstmid_grant_id got=%0b want=0", grant_id); end
        repeat (2) @(negedge clk);
        checks++; if (out_q.size() !== 0) begin errors++; $display("FAIL rstmid_flushed got=%0d beats want=0", out_q.size()); end
        @(posedge clk); #1;
        add_exp(0, 1, 32'h5A5A0001, 4'b0001, 1'b1);
        add_exp(1, 1, 32'h5A5A0002, 4'b1000, 1'b1);
        fork
            send_pkt(0, 1, 32'h5A5A0001, 4'b0001, 1'b1, 1'b0);
            send_pkt(1, 1, 32'h5A5A0002, 4'b1000, 1'b1, 1'b0);
        join
        wait_drain();
        checks++;
        if (out_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL rstmid_count got=%0d want=%0d", out_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_beat%0d got=%h want=%h", i, out_q[i], exp_q[i]); end
            end
        end
    endtask

`ifdef SWAP_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        send_pkt(0, 1, 32'h00000001, 4'hF, 1'b1, 1'b0);
        send_pkt(0, 2, 32'h00000002, 4'hF, 1'b0, 1'b0);
        send_pkt(0, 1, 32'h00000003, 4'hF, 1'b1, 1'b0);
        send_pkt(1, 1, 32'h00000004, 4'hF, 1'b0, 1'b0);
        send_pkt(0, 3, 32'h00000005, 4'hF, 1'b1, 1'b0);
        send_pkt(1, 2, 32'h00000006, 4'hF, 1'b0, 1'b0);
        send_pkt(0, 1, 32'h00000007, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (pkt_cnt0 !== 32'd5) begin errors++; $display("FAIL stats_pkt_cnt0 got=%0d want=5", pkt_cnt0); end
        checks++; if (pkt_cnt1 !== 32'd2) begin errors++; $display("FAIL stats_pkt_cnt1 got=%0d want=2", pkt_cnt1); end
        checks++; if (swap_cnt !== 32'd3) begin errors++; $display("FAIL stats_swap_cnt got=%0d want=3", swap_cnt); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        m_tready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_swap_port0();
        test_alternate();
        test_swap_toggle();
        test_backpressure();
        test_reset_mid();
`ifdef SWAP_ARB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
